// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder: stalls the pipeline for LATENCY cycles per access.
// Optional macro DMEM_FAULT_EN adds addrFault and suppresses out-of-range accesses.
module data_mem_responder #(
  parameter int unsigned DATA_DEPTH = 1024,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] memAddr,
  input  logic [31:0] memWriteData,
  input  logic        memRead,
  input  logic        memWrite,
  output logic [31:0] readData,
`ifdef DMEM_FAULT_EN
  output logic        addrFault,
`endif
  output logic        dataReady
);

  localparam int unsigned AW = $clog2(DATA_DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] capAddr;
  logic [31:0] capData;
  logic        capWrite;

  logic        req;
  logic        accGo;
  logic        accWrite;
  logic        inRange;
  logic [31:0] accAddr;
  logic [31:0] accData;
  logic        unusedAddrBits;

  logic [31:0] mem [DATA_DEPTH] = '{default: '0};

  assign req = memRead | memWrite;

  // With LATENCY==1 the access happens on the same edge that leaves IDLE,
  // so the live inputs stand in for the not-yet-captured values.
  always_comb begin
    accAddr  = capAddr;
    accData  = capData;
    accWrite = capWrite;
    if (state == IDLE) begin
      accAddr  = memAddr;
      accData  = memWriteData;
      accWrite = memWrite;
    end
    accGo = rst && (((state == IDLE) && req && (LATENCY == 1)) ||
                    ((state == BUSY) && (cnt == 4'd1)));
`ifdef DMEM_FAULT_EN
    inRange = (accAddr < DATA_DEPTH);
`else
    inRange = 1'b1;
`endif
    dataReady = rst && (((state == IDLE) && req) || (state == BUSY));
  end

  assign unusedAddrBits = ^accAddr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      readData <= '0;
`ifdef DMEM_FAULT_EN
      addrFault <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            capAddr  <= memAddr;
            capData  <= memWriteData;
            capWrite <= memWrite;
            if (LATENCY > 1) begin
              state <= BUSY;
              cnt   <= 4'(LATENCY - 1);
            end else begin
              state <= DONE;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (accGo && !accWrite && inRange) readData <= mem[accAddr[AW-1:0]];
`ifdef DMEM_FAULT_EN
      if (accGo) addrFault <= !inRange;
`endif
    end
  end

  // Storage is never reset; accGo already excludes cycles with rst low.
  always_ff @(posedge clk) begin
    if (accGo && accWrite && inRange) mem[accAddr[AW-1:0]] <= accData;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (LATENCY=2, DATA_DEPTH=1024).
module tb_data_mem_responder;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic        memRead;
  logic        memWrite;
  logic [31:0] readData;
  logic        dataReady;
`ifdef DMEM_FAULT_EN
  logic        addrFault;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_DEPTH(1024), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .memAddr      (memAddr),
    .memWriteData (memWriteData),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .readData     (readData),
`ifdef DMEM_FAULT_EN
    .addrFault    (addrFault),
`endif
    .dataReady    (dataReady)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, scrambles inputs after the first cycle, counts stall
  // cycles and returns readData as seen in the DONE cycle.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input string nm, output logic [31:0] rdOut);
    int n = 0;
    memRead = rd; memWrite = wr; memAddr = a; memWriteData = d;
    #1;
    while (dataReady === 1'b1 && n < 20) begin
      n++;
      tick();
      memRead = 1'b0; memWrite = 1'b0; memAddr = ~a; memWriteData = ~d;
      #1;
    end
    tests++;
    if (n != int'(LAT)) begin
      fails++;
      $display("FAIL %s_stall: got %0d cycles, expected %0d", nm, n, LAT);
    end
    rdOut = readData;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; memRead = 1'b1; memWrite = 1'b0; memAddr = 32'd5; memWriteData = '0;
    tick(); tick(); tick();
    tests++;
    if (dataReady !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b, expected 0", dataReady); end
    tests++;
    if (readData !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h, expected 0", readData); end
    memRead = 1'b0;
    #1 rst = 1'b1;
    tick();
  endtask

  task automatic test_store_load();
    logic [31:0] r;
    access(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, "store5", r);
    tests++;
    if (r !== 32'h0) begin fails++; $display("FAIL store5_rdata: got %h, expected 00000000", r); end
    access(1'b1, 1'b0, 32'd5, 32'h0, "load5", r);
    tests++;
    if (r !== 32'hDEADBEEF) begin fails++; $display("FAIL load5: got %h, expected deadbeef", r); end
    access(1'b1, 1'b0, 32'd100, 32'h0, "load100", r);
    tests++;
    if (r !== 32'h0) begin fails++; $display("FAIL unwritten100: got %h, expected 00000000", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    access(1'b0, 1'b1, 32'd7, 32'h77770007, "store7", r);
    access(1'b0, 1'b1, 32'd8, 32'h88880008, "store8", r);
    memRead = 1'b1; memWrite = 1'b0; memAddr = 32'd7;
    #1;
    tests++;
    if (dataReady !== 1'b1) begin fails++; $display("FAIL b2b_idle1: got %b, expected 1", dataReady); end
    tick();
    tests++;
    if (dataReady !== 1'b1) begin fails++; $display("FAIL b2b_busy1: got %b, expected 1", dataReady); end
    tick();
    tests++;
    if (dataReady !== 1'b0 || readData !== 32'h77770007) begin
      fails++; $display("FAIL b2b_done1: got ready=%b data=%h, expected 0 77770007", dataReady, readData);
    end
    memAddr = 32'd8;
    tick();
    tests++;
    if (dataReady !== 1'b1) begin fails++; $display("FAIL b2b_idle2: got %b, expected 1", dataReady); end
    tick();
    tests++;
    if (dataReady !== 1'b1) begin fails++; $display("FAIL b2b_busy2: got %b, expected 1", dataReady); end
    tick();
    tests++;
    if (dataReady !== 1'b0 || readData !== 32'h88880008) begin
      fails++; $display("FAIL b2b_done2: got ready=%b data=%h, expected 0 88880008", dataReady, readData);
    end
    memRead = 1'b0;
    tick();
    tests++;
    if (dataReady !== 1'b0 || readData !== 32'h88880008) begin
      fails++; $display("FAIL b2b_after: got ready=%b data=%h, expected 0 88880008", dataReady, readData);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    logic [31:0] r;
    access(1'b1, 1'b1, 32'd3, 32'h12345678, "both3", r);
    tests++;
    if (r !== 32'h88880008) begin fails++; $display("FAIL both3_rdata: got %h, expected 88880008", r); end
    access(1'b1, 1'b0, 32'd3, 32'h0, "load3", r);
    tests++;
    if (r !== 32'h12345678) begin fails++; $display("FAIL load3: got %h, expected 12345678", r); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    access(1'b0, 1'b1, 32'd9, 32'h99990009, "store9", r);
    access(1'b1, 1'b0, 32'd9, 32'h0, "load9a", r);
    memRead = 1'b0; memWrite = 1'b1; memAddr = 32'd9; memWriteData = 32'hBAD0BAD0;
    tick();
    rst = 1'b0;
    #1;
    tests++;
    if (dataReady !== 1'b0) begin fails++; $display("FAIL rstmid_ready: got %b, expected 0", dataReady); end
    memWrite = 1'b0;
    tick();
    tests++;
    if (dataReady !== 1'b0 || readData !== 32'h0) begin
      fails++; $display("FAIL rstmid_after: got ready=%b data=%h, expected 0 00000000", dataReady, readData);
    end
    rst = 1'b1;
    tick();
    access(1'b1, 1'b0, 32'd9, 32'h0, "load9b", r);
    tests++;
    if (r !== 32'h99990009) begin fails++; $display("FAIL rstmid_kept: got %h, expected 99990009", r); end
  endtask

  task automatic test_idle();
    memRead = 1'b0; memWrite = 1'b0; memAddr = 32'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (dataReady !== 1'b0 || readData !== 32'h99990009) begin
        fails++; $display("FAIL idle%0d: got ready=%b data=%h, expected 0 99990009", i, dataReady, readData);
      end
    end
  endtask

`ifdef DMEM_FAULT_EN
  task automatic test_fault();
    logic [31:0] r;
    access(1'b1, 1'b0, 32'd2000, 32'h0, "fault2000", r);
    tests++;
    if (r !== 32'h99990009 || addrFault !== 1'b1) begin
      fails++; $display("FAIL fault2000: got data=%h fault=%b, expected 99990009 1", r, addrFault);
    end
    access(1'b0, 1'b1, 32'd1028, 32'hA5A5A5A5, "faultstore", r);
    access(1'b1, 1'b0, 32'd4, 32'h0, "load4", r);
    tests++;
    if (r !== 32'h0 || addrFault !== 1'b0) begin
      fails++; $display("FAIL fault_nowrite: got data=%h fault=%b, expected 00000000 0", r, addrFault);
    end
    access(1'b1, 1'b0, 32'd2000, 32'h0, "fault2000b", r);
    access(1'b1, 1'b0, 32'd0, 32'h0, "load0", r);
    tests++;
    if (addrFault !== 1'b0 || r !== 32'h0) begin
      fails++; $display("FAIL fault_clear: got data=%h fault=%b, expected 00000000 0", r, addrFault);
    end
  endtask
`else
  task automatic test_wrap();
    logic [31:0] r;
    access(1'b0, 1'b1, 32'd1028, 32'hA5A5A5A5, "store1028", r);
    access(1'b1, 1'b0, 32'd4, 32'h0, "load4", r);
    tests++;
    if (r !== 32'hA5A5A5A5) begin fails++; $display("FAIL wrap4: got %h, expected a5a5a5a5", r); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    test_idle();
`ifdef DMEM_FAULT_EN
    test_fault();
`else
    test_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
